twiddle_fetch: RTL and testbench
================================

Name: twiddle_fetch

Overview:
- Reader-side sequencer for the 64-point twiddle ROM.
- For one radix-2 DIF stage, walks butterflies j = 0..31 and computes the twiddle index for each.
- Drives the ROM address, enable and tristate controls, and reads the real word, then the imaginary word.
- Presents each twiddle pair to the butterfly datapath under a valid/ready handshake.

Parameters:
- ROM_ADD_WIDTH, 6, ROM address width. Must match the ROM_ADD_WIDTH define.
- ROM_DATA_WIDTH, 16, twiddle word width, Q1.15 two's complement.
- N_LOG2, 6, log2 of FFT size. Butterflies per stage = 2^(N_LOG2-1) = 32.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start a stage sweep; sampled only in IDLE.
- i_stage  in  3  stage number s, 0..5.
- o_busy  out  1  high from sweep accept until DONE.
- o_done  out  1  one-cycle pulse after the last pair is handshaken.
- o_rom_address  out  6  ROM address.
- o_rom_read_en  out  1  ROM read enable.
- o_rom_ce  out  1  ROM chip enable.
- o_rom_tri_output  out  1  ROM output tristate: 0 = drive, 1 = Z.
- i_rom_data  in  16  ROM data; combinational from address.
- o_tw_valid  out  1  twiddle pair valid.
- i_tw_ready  in  1  consumer ready.
- o_tw_re  out  16  real part, cos(2πk/64).
- o_tw_im  out  16  imaginary part, -sin(2πk/64).
- o_tw_index  out  5  butterfly number j for the current pair.

Behaviour:
- Reset (asynchronous, while i_rst_n = 0), all outputs and state forced to:
  - state IDLE, j = 0.
  - o_busy, o_done, o_tw_valid, o_rom_read_en, o_rom_ce = 0.
  - o_rom_tri_output = 1.
  - o_rom_address, o_tw_re, o_tw_im, o_tw_index = 0.
- ROM layout: address 2k holds re(k), address 2k+1 holds im(k), k = 0..31.
- Index rule: k = (j << s) & 31, computed at 5-bit width. s ≥ 5 therefore gives k = 0 for all j; values 6 and 7 are legal and produce the same result.
- FSM states: IDLE, RD_RE, RD_IM, PRESENT, DONE.
  - IDLE: if i_start = 1, latch i_stage, set j = 0, o_busy = 1, go to RD_RE. Otherwise stay.
  - RD_RE: address = {k, 0}; ce = read_en = 1; tri = 0. Capture i_rom_data into o_tw_re at the clock edge; go to RD_IM.
  - RD_IM: address = {k, 1}; same controls. Capture into o_tw_im; go to PRESENT.
  - PRESENT: o_tw_valid = 1; ROM ce = read_en = 0, tri = 1. o_tw_re, o_tw_im and o_tw_index stay stable while valid and not ready. On valid & ready: if j = 31 go to DONE, else j = j+1 and go to RD_RE.
  - DONE: o_done = 1 for one cycle, o_busy = 0, then IDLE.
- Latency: start accepted at edge E0; o_tw_valid is high after E2. With ready held high, one pair every 3 cycles and 96 cycles per stage.
- ROM controls are active only in RD_RE and RD_IM. In all other states ce = 0 and tri = 1, so the ROM bus is Z.
- i_start while busy is ignored. i_stage is used only as latched at accept.
- o_tw_valid never drops without a handshake.
- Reset mid-sweep aborts immediately: back to IDLE, no o_done pulse.

Optional Feature:
- Macro: TWIDDLE_CONJ_EN.
- Defined:
  - Adds input i_inverse (1 bit), latched at accept.
  - When the latched value is 1, o_tw_im is the saturated negation of the ROM word: 0x8000 maps to 0x7FFF, otherwise two's-complement negate.
  - The negation is applied at capture, so latency is unchanged.
- Undefined: no i_inverse port; o_tw_im is the ROM word unchanged.

Decomposition:
- The shared defines file (00defines.v) holds:
  - ROM_ADD_WIDTH and ROM_DATA_WIDTH (existing).
  - New TWF_IDLE, TWF_RD_RE, TWF_RD_IM, TWF_PRESENT, TWF_DONE state encodings, 3 bits.
  - TWF_NBFLY = 32.
- One natural sub-module: twf_conj_sat, the combinational saturating negate. It is instantiated only under TWIDDLE_CONJ_EN.
- Index generation stays inline.

Test Plan:
1. Reset, then stage 0 with ready held high -> 32 pairs.
   - Pair 0: re 0x7FFF, im 0x0000.
   - Pair 1: re 0x7F62, im 0xF375.
   - Pair 16: re 0x0000, im 0x8000.
   - o_done pulses once, 96 cycles after start.
2. Stage 2 -> j = 1 gives k = 4, addresses 8 and 9, re 0x7641, im 0xCF05. j = 8 wraps to k = 0.
3. Stage 5 -> all 32 pairs are 0x7FFF / 0x0000. ROM addresses only 0 and 1.
4. Backpressure: hold i_tw_ready low for 10 cycles at j = 3 -> valid, data and index stay stable, no ROM access (ce = 0, tri = 1), then resume.
5. Assert i_rst_n low during RD_IM of j = 7 -> outputs return to reset values immediately, no o_done. A new start with i_stage 0 restarts at j = 0.
6. TWIDDLE_CONJ_EN, i_inverse = 1, stage 0:
   - j = 1: im 0x0C8B.
   - j = 16: im 0x7FFF (saturated).
   - j = 0: im 0x0000.

Source files
------------

// File: rtl/twiddle_fetch_pkg.sv
// Shared constants for the twiddle ROM reader: ROM geometry, sequencer state
// encodings and the butterfly count of one radix-2 stage.
package twiddle_fetch_pkg;
  localparam int TWF_ROM_AW = 6;
  localparam int TWF_ROM_DW = 16;
  localparam int TWF_N_LOG2 = 6;
  localparam int TWF_NBFLY  = 32;

  localparam logic [2:0] TWF_IDLE    = 3'd0;
  localparam logic [2:0] TWF_RD_RE   = 3'd1;
  localparam logic [2:0] TWF_RD_IM   = 3'd2;
  localparam logic [2:0] TWF_PRESENT = 3'd3;
  localparam logic [2:0] TWF_DONE    = 3'd4;
endpackage

// File: rtl/twf_conj_sat.sv
// Combinational saturating two's-complement negate; the most negative code
// maps to the most positive one instead of wrapping onto itself.
module twf_conj_sat #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  output logic [W-1:0] y_o
);
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  assign y_o = (a_i == MIN_NEG) ? ~MIN_NEG : (~a_i + 1'b1);
endmodule

// File: rtl/twiddle_fetch.sv
// Twiddle ROM reader for one radix-2 DIF stage: reads re/im for each butterfly
// and hands the pair over valid/ready. Optional TWIDDLE_CONJ_EN adds i_inverse.
module twiddle_fetch
  import twiddle_fetch_pkg::*;
#(
  parameter int ROM_ADD_WIDTH  = TWF_ROM_AW,
  parameter int ROM_DATA_WIDTH = TWF_ROM_DW,
  parameter int N_LOG2         = TWF_N_LOG2
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_start,
  input  logic [2:0]                i_stage,
`ifdef TWIDDLE_CONJ_EN
  input  logic                      i_inverse,
`endif
  output logic                      o_busy,
  output logic                      o_done,
  output logic [ROM_ADD_WIDTH-1:0]  o_rom_address,
  output logic                      o_rom_read_en,
  output logic                      o_rom_ce,
  output logic                      o_rom_tri_output,
  input  logic [ROM_DATA_WIDTH-1:0] i_rom_data,
  output logic                      o_tw_valid,
  input  logic                      i_tw_ready,
  output logic [ROM_DATA_WIDTH-1:0] o_tw_re,
  output logic [ROM_DATA_WIDTH-1:0] o_tw_im,
  output logic [N_LOG2-2:0]         o_tw_index
);
  localparam int JW = N_LOG2 - 1;
  localparam logic [JW-1:0] J_LAST = {JW{1'b1}};

  logic [2:0]                state_q, state_d;
  logic [2:0]                stage_q, stage_d;
  logic [JW-1:0]             j_q, j_d;
  logic [ROM_DATA_WIDTH-1:0] re_q, re_d, im_q, im_d;
  logic [ROM_DATA_WIDTH-1:0] im_cap;
  logic [JW-1:0]             k;
  logic [N_LOG2-1:0]         addr;
  logic                      rd_act;

  // Shift at index width so high bits fall off: stages >= JW collapse to k = 0.
  assign k = j_q << stage_q;

`ifdef TWIDDLE_CONJ_EN
  logic                      inv_q, inv_d;
  logic [ROM_DATA_WIDTH-1:0] im_neg;

  twf_conj_sat #(.W(ROM_DATA_WIDTH)) u_conj (
    .a_i (i_rom_data),
    .y_o (im_neg)
  );

  assign im_cap = inv_q ? im_neg : i_rom_data;
`else
  assign im_cap = i_rom_data;
`endif

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    j_d     = j_q;
    re_d    = re_q;
    im_d    = im_q;
`ifdef TWIDDLE_CONJ_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      TWF_IDLE: if (i_start) begin
        state_d = TWF_RD_RE;
        stage_d = i_stage;
        j_d     = '0;
`ifdef TWIDDLE_CONJ_EN
        inv_d   = i_inverse;
`endif
      end
      TWF_RD_RE: begin
        re_d    = i_rom_data;
        state_d = TWF_RD_IM;
      end
      TWF_RD_IM: begin
        im_d    = im_cap;
        state_d = TWF_PRESENT;
      end
      TWF_PRESENT: if (i_tw_ready) begin
        if (j_q == J_LAST) begin
          state_d = TWF_DONE;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = TWF_RD_RE;
        end
      end
      TWF_DONE: state_d = TWF_IDLE;
      default:  state_d = TWF_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= TWF_IDLE;
      stage_q <= '0;
      j_q     <= '0;
      re_q    <= '0;
      im_q    <= '0;
`ifdef TWIDDLE_CONJ_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      j_q     <= j_d;
      re_q    <= re_d;
      im_q    <= im_d;
`ifdef TWIDDLE_CONJ_EN
      inv_q   <= inv_d;
`endif
    end
  end

  // ROM is only driven during the two read states; the bus floats otherwise.
  assign rd_act           = (state_q == TWF_RD_RE) || (state_q == TWF_RD_IM);
  assign addr             = rd_act ? {k, (state_q == TWF_RD_IM)} : '0;
  assign o_rom_address    = addr;
  assign o_rom_ce         = rd_act;
  assign o_rom_read_en    = rd_act;
  assign o_rom_tri_output = ~rd_act;

  assign o_busy     = rd_act || (state_q == TWF_PRESENT);
  assign o_done     = (state_q == TWF_DONE);
  assign o_tw_valid = (state_q == TWF_PRESENT);
  assign o_tw_re    = re_q;
  assign o_tw_im    = im_q;
  assign o_tw_index = j_q;
endmodule

// File: tb/tb_twiddle_fetch.sv
// Directed bench for twiddle_fetch: ROM model built from Q1.15 cos/sin, spot
// vectors table, backpressure, mid-sweep reset and (if enabled) conjugation.
module tb_twiddle_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic [2:0]  stage = 3'd0;
`ifdef TWIDDLE_CONJ_EN
  logic        inverse = 1'b0;
`endif
  logic        busy, done, rd_en, ce, tri_o, valid;
  logic [5:0]  addr;
  logic [15:0] rom_data, re, im;
  logic [4:0]  idx;

  always #5 clk = ~clk;

  twiddle_fetch dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_start          (start),
    .i_stage          (stage),
`ifdef TWIDDLE_CONJ_EN
    .i_inverse        (inverse),
`endif
    .o_busy           (busy),
    .o_done           (done),
    .o_rom_address    (addr),
    .o_rom_read_en    (rd_en),
    .o_rom_ce         (ce),
    .o_rom_tri_output (tri_o),
    .i_rom_data       (rom_data),
    .o_tw_valid       (valid),
    .i_tw_ready       (ready),
    .o_tw_re          (re),
    .o_tw_im          (im),
    .o_tw_index       (idx)
  );

  logic [15:0] rom [0:63];
  // Garbage when the ROM is not selected, so a mistimed capture shows up.
  assign rom_data = ce ? rom[addr] : 16'hDEAD;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: records handshaken pairs, read addresses and control violations.
  logic        clr = 1'b0;
  int          cap_cnt, done_cnt, ctl_err, max_addr;
  logic [15:0] cap_re [32];
  logic [15:0] cap_im [32];
  logic [5:0]  addr_re [32];

  always @(negedge clk) begin
    if (clr) begin
      cap_cnt  <= 0;
      done_cnt <= 0;
      ctl_err  <= 0;
      max_addr <= 0;
      for (int j = 0; j < 32; j++) begin
        cap_re[j]  <= 16'h5A5A;
        cap_im[j]  <= 16'h5A5A;
        addr_re[j] <= 6'h3F;
      end
    end else begin
      if (valid && ready) begin
        cap_re[idx] <= re;
        cap_im[idx] <= im;
        cap_cnt     <= cap_cnt + 1;
        if (idx != cap_cnt[4:0]) ctl_err <= ctl_err + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (ce) begin
        if (!rd_en || tri_o || valid) ctl_err <= ctl_err + 1;
        if (int'(addr) > max_addr) max_addr <= int'(addr);
        if (!addr[0]) addr_re[idx] <= addr;
      end else if (rd_en || !tri_o) begin
        ctl_err <= ctl_err + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"},  32'(busy),  0);
    chk({tag, "_done"},  32'(done),  0);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_rden"},  32'(rd_en), 0);
    chk({tag, "_ce"},    32'(ce),    0);
    chk({tag, "_tri"},   32'(tri_o), 1);
    chk({tag, "_addr"},  32'(addr),  0);
    chk({tag, "_re"},    32'(re),    0);
    chk({tag, "_im"},    32'(im),    0);
    chk({tag, "_idx"},   32'(idx),   0);
  endtask

  task automatic clear_mon();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  function automatic logic [15:0] sat_neg(input logic [15:0] v);
    if (v == 16'h8000) return 16'h7FFF;
    return 16'(-int'($signed(v)));
  endfunction

  // One full stage sweep with an optional 10-cycle stall at butterfly stall_j.
  task automatic sweep(input logic [2:0] s, input int stall_j, input int exp_lat, input bit inv);
    int t0, lat, mism, kk, emax, stall_err;
    logic [15:0] e_im, s_re, s_im;
    logic [4:0]  s_idx;
    bit stalled;
    clear_mon();
    @(negedge clk);
    stage = s;
    start = 1'b1;
`ifdef TWIDDLE_CONJ_EN
    inverse = inv;
`endif
    @(posedge clk);
    #1 t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    stage = 3'd3;
`ifdef TWIDDLE_CONJ_EN
    inverse = ~inv;
`endif
    chk("busy_at_accept", 32'(busy), 1);
    chk("valid_E0", 32'(valid), 0);
    @(negedge clk);
    chk("valid_E1", 32'(valid), 0);
    @(negedge clk);
    chk("valid_E2", 32'(valid), 1);
    lat = -1;
    stalled = 1'b0;
    for (int i = 3; i < 300; i++) begin
      if (done) begin
        lat = cyc - t0;
        break;
      end
      if (stall_j >= 0 && !stalled && valid && int'(idx) == stall_j) begin
        ready = 1'b0;
        stalled = 1'b1;
        s_re = re; s_im = im; s_idx = idx;
        stall_err = 0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (!valid || re != s_re || im != s_im || idx != s_idx || ce || !tri_o || !busy)
            stall_err++;
        end
        chk("stall_hold", 32'(stall_err), 0);
        ready = 1'b1;
      end
      start = (i == 10);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("sweep_latency", 32'(lat), 32'(exp_lat));
    chk("pair_count", 32'(cap_cnt), 32);
    chk("done_pulses", 32'(done_cnt), 1);
    chk("rom_ctl_order", 32'(ctl_err), 0);
    chk("busy_after", 32'(busy), 0);
    mism = 0;
    emax = 0;
    for (int j = 0; j < 32; j++) begin
      kk = (j << s) & 31;
      e_im = inv ? sat_neg(rom[2*kk+1]) : rom[2*kk+1];
      if (cap_re[j] != rom[2*kk] || cap_im[j] != e_im) begin
        if (mism == 0)
          $display("FAIL pair_j%0d: got re 0x%h im 0x%h, expected re 0x%h im 0x%h",
                   j, cap_re[j], cap_im[j], rom[2*kk], e_im);
        mism++;
      end
      if (2*kk + 1 > emax) emax = 2*kk + 1;
    end
    chk("pairs_vs_model", 32'(mism), 0);
    chk("max_rom_addr", 32'(max_addr), 32'(emax));
  endtask

  typedef struct {
    logic [2:0]  s;
    int          j;
    logic [5:0]  a;
    logic [15:0] re;
    logic [15:0] im;
  } vec_t;

  vec_t vt [8];
  real  cv, sv;
  int   ci, si, cur, found;

  initial begin
    for (int k = 0; k < 32; k++) begin
      cv = $cos(2.0 * 3.141592653589793 * k / 64.0) * 32768.0;
      sv = -$sin(2.0 * 3.141592653589793 * k / 64.0) * 32768.0;
      ci = $rtoi(cv);
      si = $rtoi(sv);
      if (ci > 32767) ci = 32767;
      if (si > 32767) si = 32767;
      rom[2*k]   = ci[15:0];
      rom[2*k+1] = si[15:0];
    end

    vt[0] = '{3'd0, 0,  6'd0,  16'h7FFF, 16'h0000};
    vt[1] = '{3'd0, 1,  6'd2,  16'h7F62, 16'hF375};
    vt[2] = '{3'd0, 16, 6'd32, 16'h0000, 16'h8000};
    vt[3] = '{3'd2, 1,  6'd8,  16'h7641, 16'hCF05};
    vt[4] = '{3'd2, 8,  6'd0,  16'h7FFF, 16'h0000};
    vt[5] = '{3'd5, 13, 6'd0,  16'h7FFF, 16'h0000};
    vt[6] = '{3'd5, 31, 6'd0,  16'h7FFF, 16'h0000};
    vt[7] = '{3'd7, 5,  6'd0,  16'h7FFF, 16'h0000};

    #2 check_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    cur = -1;
    for (int i = 0; i < 8; i++) begin
      if (int'(vt[i].s) != cur) begin
        sweep(vt[i].s, -1, 96, 1'b0);
        cur = int'(vt[i].s);
      end
      chk($sformatf("vec%0d_addr", i), 32'(addr_re[vt[i].j]), 32'(vt[i].a));
      chk($sformatf("vec%0d_re", i),   32'(cap_re[vt[i].j]),  32'(vt[i].re));
      chk($sformatf("vec%0d_im", i),   32'(cap_im[vt[i].j]),  32'(vt[i].im));
    end

    // Backpressure at j = 3 on stage 1 (k = 6): 10 stall cycles added.
    sweep(3'd1, 3, 106, 1'b0);
    chk("stall_pair_re", 32'(cap_re[3]), 32'(rom[12]));

    // Reset while reading the imaginary word of j = 7.
    clear_mon();
    @(negedge clk); stage = 3'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int i = 0; i < 80 && found == 0; i++) begin
      @(negedge clk);
      if (ce && addr[0] && idx == 5'd7) found = 1;
    end
    chk("rst_trigger", 32'(found), 1);
    rst_n = 1'b0;
    #1 check_reset_vals("abort");
    repeat (5) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 0);
    chk("abort_pairs", 32'(cap_cnt), 7);
    rst_n = 1'b1;
    sweep(3'd0, -1, 96, 1'b0);
    chk("restart_j1_re", 32'(cap_re[1]), 32'h7F62);

`ifdef TWIDDLE_CONJ_EN
    sweep(3'd0, -1, 96, 1'b1);
    chk("conj_j1_im",  32'(cap_im[1]),  32'h0C8B);
    chk("conj_j16_im", 32'(cap_im[16]), 32'h7FFF);
    chk("conj_j0_im",  32'(cap_im[0]),  32'h0000);
    chk("conj_j1_re",  32'(cap_re[1]),  32'h7F62);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
